// File: rtl/contador_descendente_pkg.sv
// Shared definitions for the loadable down-counter: FSM state encoding and default width.
package contador_descendente_pkg;

    localparam int unsigned CONT_N_BITS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } cont_state_t;

endpackage : contador_descendente_pkg

// File: rtl/contador_reg.sv
// N_BITS count register with synchronous reset, parallel load and guarded decrement.
// Produces the count and its registered bitwise complement on the same edge.
module contador_reg
    import contador_descendente_pkg::*;
#(
    parameter int unsigned N_BITS = CONT_N_BITS_DEF
) (
    input  logic              clock,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [N_BITS-1:0] i_din,
    input  logic              i_dec,
    output logic [N_BITS-1:0] o_out,
    output logic [N_BITS-1:0] o_nout
);

    logic [N_BITS-1:0] r_out;
    logic [N_BITS-1:0] r_nout;

    // Count register; decrement never wraps below zero.
    always_ff @(posedge clock) begin
        if (i_rst) begin
            r_out  <= '0;
            r_nout <= '1;
        end else if (i_load) begin
            r_out  <= i_din;
            r_nout <= ~i_din;
        end else if (i_dec && (r_out != '0)) begin
            r_out  <= r_out - N_BITS'(1);
            r_nout <= ~(r_out - N_BITS'(1));
        end
    end

    assign o_out  = r_out;
    assign o_nout = r_nout;

endmodule : contador_reg

// File: rtl/contador_descendente.sv
// Loadable synchronous down-counter/timer with a one-cycle terminal pulse.
// Optional feature macro: CONT_AUTO_RELOAD_EN (reloads the last loaded value on
// every terminal count, turning the block into a periodic tick generator).
module contador_descendente
    import contador_descendente_pkg::*;
#(
    parameter int unsigned N_BITS = CONT_N_BITS_DEF
) (
    input  logic              clock,
    input  logic              cont_reset,
    input  logic              cont_enable,
    input  logic              cont_load,
    input  logic [N_BITS-1:0] cont_din,
    output logic [N_BITS-1:0] cont_out,
    output logic [N_BITS-1:0] cont_nout,
    output logic              cont_busy,
    output logic              cont_done
);

    cont_state_t       r_state;
    cont_state_t       w_state_nxt;
    logic              w_reg_load;
    logic [N_BITS-1:0] w_reg_din;
    logic              w_reg_dec;
    logic [N_BITS-1:0] w_out;
    logic [N_BITS-1:0] w_nout;
    logic [N_BITS-1:0] w_reload_val;
    logic              r_busy;
    logic              r_done;

`ifdef CONT_AUTO_RELOAD_EN
    logic [N_BITS-1:0] r_reload;

    // Reload register captures every accepted load.
    always_ff @(posedge clock) begin
        if (cont_reset) begin
            r_reload <= '0;
        end else if (cont_load) begin
            r_reload <= cont_din;
        end
    end

    assign w_reload_val = r_reload;
`else
    assign w_reload_val = '0;
`endif

    // State register plus busy/done flags registered from the next state.
    always_ff @(posedge clock) begin
        if (cont_reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_COUNT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Next-state and count-register control; load outranks enable in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_reg_load  = 1'b0;
        w_reg_din   = cont_din;
        w_reg_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cont_load) begin
                    w_reg_load  = 1'b1;
                    w_state_nxt = (cont_din != '0) ? ST_COUNT : ST_DONE;
                end
            end
            ST_COUNT: begin
                if (cont_load) begin
                    w_reg_load  = 1'b1;
                    w_state_nxt = (cont_din != '0) ? ST_COUNT : ST_DONE;
                end else if (cont_enable) begin
                    if (w_out > N_BITS'(1)) begin
                        w_reg_dec = 1'b1;
                    end else begin
                        // Terminal count: land on the reload value (zero without the feature).
                        w_reg_load  = 1'b1;
                        w_reg_din   = w_reload_val;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (cont_load) begin
                    w_reg_load  = 1'b1;
                    w_state_nxt = (cont_din != '0) ? ST_COUNT : ST_DONE;
                end else begin
                    w_state_nxt = (w_reload_val != '0) ? ST_COUNT : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    contador_reg #(
        .N_BITS (N_BITS)
    ) u_reg (
        .clock  (clock),
        .i_rst  (cont_reset),
        .i_load (w_reg_load),
        .i_din  (w_reg_din),
        .i_dec  (w_reg_dec),
        .o_out  (w_out),
        .o_nout (w_nout)
    );

    assign cont_out  = w_out;
    assign cont_nout = w_nout;
    assign cont_busy = r_busy;
    assign cont_done = r_done;

endmodule : contador_descendente

// File: tb/tb_contador_descendente.sv
// Self-checking bench for contador_descendente: directed scenarios plus a random run,
// all compared against a behavioural model of the counter kept in this file.
module tb_contador_descendente;

    localparam int unsigned N = 8;
`ifdef CONT_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         cont_reset;
    logic         cont_enable;
    logic         cont_load;
    logic [N-1:0] cont_din;
    logic [N-1:0] cont_out;
    logic [N-1:0] cont_nout;
    logic         cont_busy;
    logic         cont_done;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: integer count, busy/done flags, remembered reload value.
    int m_out    = 0;
    int m_reload = 0;
    bit m_busy   = 1'b0;
    bit m_done   = 1'b0;

    always #5 clock = ~clock;

    contador_descendente #(.N_BITS(N)) dut (
        .clock       (clock),
        .cont_reset  (cont_reset),
        .cont_enable (cont_enable),
        .cont_load   (cont_load),
        .cont_din    (cont_din),
        .cont_out    (cont_out),
        .cont_nout   (cont_nout),
        .cont_busy   (cont_busy),
        .cont_done   (cont_done)
    );

    task automatic model_step(input bit rst, input bit ld, input bit en, input int din);
        if (rst) begin
            m_out = 0; m_busy = 1'b0; m_done = 1'b0; m_reload = 0;
        end else if (ld) begin
            if (AUTO) m_reload = din;
            m_out  = din;
            m_busy = (din != 0);
            m_done = (din == 0);
        end else if (m_busy) begin
            if (en) begin
                if (m_out > 1) m_out = m_out - 1;
                else begin
                    m_out = m_reload; m_busy = 1'b0; m_done = 1'b1;
                end
            end
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = (m_reload != 0);
        end
    endtask

    // Apply inputs away from the edge, advance the model, sample 1 time unit after the edge.
    task automatic do_edge(input bit rst, input bit ld, input bit en, input int din);
        @(negedge clock);
        cont_reset  = rst;
        cont_load   = ld;
        cont_enable = en;
        cont_din    = N'(din);
        model_step(rst, ld, en, din);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            do_edge(1'b1, 1'b1, 1'b1, 8'h55);
            n_cmp++;
            if ({cont_out, cont_nout, cont_busy, cont_done} !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset[%0d]: out=%h nout=%h busy=%b done=%b, expected 00 FF 0 0",
                         i, cont_out, cont_nout, cont_busy, cont_done);
            end
        end
    endtask

    task automatic test_basic_count();
        int exp_seq[5] = '{5, 4, 3, 2, 1};
        do_edge(1'b0, 1'b1, 1'b1, 5);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) do_edge(1'b0, 1'b0, 1'b1, 0);
            n_cmp++;
            if ({cont_out, cont_nout, cont_busy, cont_done} !== {N'(exp_seq[i]), ~N'(exp_seq[i]), 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL basic_count[%0d]: out=%h busy=%b done=%b, expected %h 1 0",
                         i, cont_out, cont_busy, cont_done, N'(exp_seq[i]));
            end
        end
        do_edge(1'b0, 1'b0, 1'b1, 0);
        n_cmp++;
        if ({cont_out, cont_busy, cont_done} !== {(AUTO ? 8'd5 : 8'd0), 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_terminal: out=%h busy=%b done=%b, expected %h 0 1",
                     cont_out, cont_busy, cont_done, (AUTO ? 8'd5 : 8'd0));
        end
        for (int i = 0; i < 3; i++) begin
            do_edge(1'b0, 1'b0, 1'b1, 0);
            n_cmp++;
            if ({cont_out, cont_nout, cont_busy, cont_done} !== {N'(m_out), ~N'(m_out), m_busy, m_done}) begin
                n_bad++;
                $display("FAIL basic_hold[%0d]: out=%h nout=%h busy=%b done=%b, expected %h %h %b %b",
                         i, cont_out, cont_nout, cont_busy, cont_done, N'(m_out), ~N'(m_out), m_busy, m_done);
            end
        end
`ifndef CONT_AUTO_RELOAD_EN
        n_cmp++;
        if (cont_out !== 8'h00) begin
            n_bad++;
            $display("FAIL basic_no_wrap: out=%h, expected 00", cont_out);
        end
`endif
        do_edge(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_enable_gaps();
        bit en_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int exp_seq[5] = '{2, 2, 2, 1, 0};
        int dones = 0;
        do_edge(1'b0, 1'b1, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            do_edge(1'b0, 1'b0, en_pat[i], 0);
            if (cont_done === 1'b1) dones++;
            n_cmp++;
            if ({cont_out, cont_nout, cont_busy, cont_done} !== {N'(m_out), ~N'(m_out), m_busy, m_done}) begin
                n_bad++;
                $display("FAIL gaps[%0d]: out=%h nout=%h busy=%b done=%b, expected %h %h %b %b",
                         i, cont_out, cont_nout, cont_busy, cont_done, N'(m_out), ~N'(m_out), m_busy, m_done);
            end
            if (!AUTO || i < 4) begin
                n_cmp++;
                if (cont_out !== N'(exp_seq[i])) begin
                    n_bad++;
                    $display("FAIL gaps_seq[%0d]: out=%h, expected %h", i, cont_out, N'(exp_seq[i]));
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_edge(1'b0, 1'b0, 1'b0, 0);
            if (cont_done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL gaps_done_count: got %0d pulses, expected 1", dones);
        end
        do_edge(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_load_zero_and_reload();
        do_edge(1'b0, 1'b1, 1'b1, 0);
        n_cmp++;
        if ({cont_out, cont_busy, cont_done} !== {8'h00, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL load_zero: out=%h busy=%b done=%b, expected 00 0 1", cont_out, cont_busy, cont_done);
        end
        do_edge(1'b0, 1'b0, 1'b1, 0);
        n_cmp++;
        if ({cont_out, cont_busy, cont_done} !== {8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL load_zero_idle: out=%h busy=%b done=%b, expected 00 0 0", cont_out, cont_busy, cont_done);
        end
        do_edge(1'b0, 1'b1, 1'b0, 10);
        for (int i = 0; i < 3; i++) do_edge(1'b0, 1'b0, 1'b1, 0);
        n_cmp++;
        if (cont_out !== 8'd7) begin
            n_bad++;
            $display("FAIL reload_mid_value: out=%h, expected 07", cont_out);
        end
        do_edge(1'b0, 1'b1, 1'b1, 2);
        n_cmp++;
        if ({cont_out, cont_busy, cont_done} !== {8'd2, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reload_restart: out=%h busy=%b done=%b, expected 02 1 0", cont_out, cont_busy, cont_done);
        end
        do_edge(1'b0, 1'b0, 1'b1, 0);
        n_cmp++;
        if ({cont_out, cont_done} !== {8'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL reload_step: out=%h done=%b, expected 01 0", cont_out, cont_done);
        end
        do_edge(1'b0, 1'b0, 1'b1, 0);
        n_cmp++;
        if ({cont_out, cont_busy, cont_done} !== {(AUTO ? 8'd2 : 8'd0), 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reload_done: out=%h busy=%b done=%b, expected %h 0 1",
                     cont_out, cont_busy, cont_done, (AUTO ? 8'd2 : 8'd0));
        end
        do_edge(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_mid_reset();
        do_edge(1'b0, 1'b1, 1'b0, 9);
        for (int i = 0; i < 4; i++) do_edge(1'b0, 1'b0, 1'b1, 0);
        n_cmp++;
        if (cont_out !== 8'd5) begin
            n_bad++;
            $display("FAIL mid_reset_pre: out=%h, expected 05", cont_out);
        end
        do_edge(1'b1, 1'b1, 1'b1, 9);
        n_cmp++;
        if ({cont_out, cont_nout, cont_busy, cont_done} !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset: out=%h nout=%h busy=%b done=%b, expected 00 FF 0 0",
                     cont_out, cont_nout, cont_busy, cont_done);
        end
        do_edge(1'b0, 1'b0, 1'b1, 0);
        n_cmp++;
        if ({cont_out, cont_busy, cont_done} !== {8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset_after: out=%h busy=%b done=%b, expected 00 0 0", cont_out, cont_busy, cont_done);
        end
    endtask

`ifdef CONT_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        int dones = 0;
        do_edge(1'b0, 1'b1, 1'b1, 3);
        for (int i = 0; i < 12; i++) begin
            do_edge(1'b0, 1'b0, 1'b1, 0);
            if (cont_done === 1'b1) dones++;
            n_cmp++;
            if ({cont_out, cont_nout, cont_busy, cont_done} !== {N'(m_out), ~N'(m_out), m_busy, m_done}) begin
                n_bad++;
                $display("FAIL auto[%0d]: out=%h busy=%b done=%b, expected %h %b %b",
                         i, cont_out, cont_busy, cont_done, N'(m_out), m_busy, m_done);
            end
        end
        n_cmp++;
        if (dones !== 3) begin
            n_bad++;
            $display("FAIL auto_done_count: got %0d pulses, expected 3", dones);
        end
        do_edge(1'b0, 1'b1, 1'b1, 0);
        do_edge(1'b0, 1'b0, 1'b1, 0);
        n_cmp++;
        if ({cont_out, cont_busy, cont_done} !== {8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL auto_stop: out=%h busy=%b done=%b, expected 00 0 0", cont_out, cont_busy, cont_done);
        end
        do_edge(1'b1, 1'b0, 1'b0, 0);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit rst = ($urandom_range(0, 63) == 0);
            bit ld  = ($urandom_range(0, 7) == 0);
            bit en  = ($urandom_range(0, 3) != 0);
            int din = (($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6)));
            do_edge(rst, ld, en, din);
            n_cmp++;
            if ({cont_out, cont_nout, cont_busy, cont_done} !== {N'(m_out), ~N'(m_out), m_busy, m_done}) begin
                n_bad++;
                $display("FAIL random[%0d]: out=%h nout=%h busy=%b done=%b, expected %h %h %b %b",
                         i, cont_out, cont_nout, cont_busy, cont_done, N'(m_out), ~N'(m_out), m_busy, m_done);
            end
            n_cmp++;
            if (cont_busy === 1'b1 && cont_done === 1'b1) begin
                n_bad++;
                $display("FAIL random_exclusive[%0d]: busy=%b done=%b, expected not both high", i, cont_busy, cont_done);
            end
        end
    endtask

    initial begin
        cont_reset  = 1'b1;
        cont_load   = 1'b0;
        cont_enable = 1'b0;
        cont_din    = '0;
        test_reset();
        test_basic_count();
        test_enable_gaps();
        test_load_zero_and_reload();
        test_mid_reset();
`ifdef CONT_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_contador_descendente
